// File: rtl/mem_pkg.sv
// Shared state type and defaults for the wait-state memory responder.
package mem_pkg;
    localparam int MEM_WORD_W    = 32;
    localparam int MEM_DEPTH_DEF = 512;
    localparam int MEM_WAIT_DEF  = 2;
    localparam int MEM_CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } mem_state_t;
endpackage

// File: rtl/mem_array.sv
// Single-port word RAM, one-cycle synchronous read (read-before-write).
// No flow control: a write or read is performed on every clock edge.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  iClk,
    input  logic                  iWe,
    input  logic [AW-1:0]         iAddr,
    input  logic [MEM_WORD_W-1:0] iD,
    output logic [MEM_WORD_W-1:0] oQ
);
    logic [MEM_WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge iClk) begin
        if (iWe) begin
            r_mem[iAddr] <= iD;
        end
        oQ <= r_mem[iAddr];
    end
endmodule

// File: rtl/mem_responder.sv
// Processor-facing memory with WAIT_CYCLES wait states; oAck at T+WAIT_CYCLES+2, requests ignored while busy.
// MEM_BOUNDS_CHECK_EN adds oErr and suppresses out-of-range accesses; otherwise addresses wrap.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH_DEF,
    parameter int WAIT_CYCLES = MEM_WAIT_DEF
) (
    input  logic                  iClk,
    input  logic                  nRst,
    input  logic                  iReq,
    input  logic                  iWrite,
    input  logic [31:0]           iAddr,
    input  logic [MEM_WORD_W-1:0] iWData,
    output logic [MEM_WORD_W-1:0] oRData,
    output logic                  oAck,
    output logic                  oBusy
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic                  oErr
`endif
);
    localparam int AW = $clog2(DEPTH);

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [MEM_CNT_W-1:0]  r_cnt;
    logic [AW-1:0]         r_idx;
    logic [MEM_WORD_W-1:0] r_wdata;
    logic                  r_write;
    logic                  w_oob;
    logic                  w_we;
    logic [AW-1:0]         w_arr_addr;
    logic [MEM_WORD_W-1:0] w_q;

    // The array sees the incoming address while idle and the latched one afterwards,
    // so oQ already holds the target word during ACCESS and oRData can be loaded entering DONE.
    assign w_arr_addr = (r_state == ST_IDLE) ? iAddr[AW+1:2] : r_idx;
    assign w_we       = (r_state == ST_ACCESS) && r_write && !w_oob && nRst;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .iClk  (iClk),
        .iWe   (w_we),
        .iAddr (w_arr_addr),
        .iD    (r_wdata),
        .oQ    (w_q)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (iReq) w_state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
            ST_WAIT:   if (r_cnt <= MEM_CNT_W'(1)) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            oRData  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (iReq) begin
                        r_idx   <= iAddr[AW+1:2];
                        r_wdata <= iWData;
                        r_write <= iWrite;
                        r_cnt   <= MEM_CNT_W'(WAIT_CYCLES);
                    end
                end
                ST_WAIT:   r_cnt <= r_cnt - MEM_CNT_W'(1);
                ST_ACCESS: if (!r_write && !w_oob) oRData <= w_q;
                default:   ;
            endcase
        end
    end

    assign oAck  = (r_state == ST_DONE);
    assign oBusy = (r_state != ST_IDLE);

`ifdef MEM_BOUNDS_CHECK_EN
    logic r_oob;
    logic w_unused;

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            r_oob <= 1'b0;
        end else if (r_state == ST_IDLE && iReq) begin
            r_oob <= |iAddr[31:AW+2];
        end
    end

    assign w_oob    = r_oob;
    assign oErr     = (r_state == ST_DONE) && r_oob;
    assign w_unused = ^iAddr[1:0];
`else
    logic w_unused;

    assign w_oob    = 1'b0;
    assign w_unused = ^{iAddr[31:AW+2], iAddr[1:0]};
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench: two responders (WAIT_CYCLES 2 and 0) checked against an array model of memory and read data.
module tb_mem_responder;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        req   [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        busy  [2];
`ifdef MEM_BOUNDS_CHECK_EN
    logic        err   [2];
`endif

    logic [31:0] mmem [2][512];
    logic [31:0] mrd  [2];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(512), .WAIT_CYCLES(2)) u_dut_w2 (
        .iClk(clk), .nRst(rst_n[0]), .iReq(req[0]), .iWrite(wr[0]), .iAddr(addr[0]),
        .iWData(wdata[0]), .oRData(rdata[0]), .oAck(ack[0]), .oBusy(busy[0])
`ifdef MEM_BOUNDS_CHECK_EN
        , .oErr(err[0])
`endif
    );

    mem_responder #(.DEPTH(512), .WAIT_CYCLES(0)) u_dut_w0 (
        .iClk(clk), .nRst(rst_n[1]), .iReq(req[1]), .iWrite(wr[1]), .iAddr(addr[1]),
        .iWData(wdata[1]), .oRData(rdata[1]), .oAck(ack[1]), .oBusy(busy[1])
`ifdef MEM_BOUNDS_CHECK_EN
        , .oErr(err[1])
`endif
    );

    function automatic int wc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit oob(input logic [31:0] a);
        return BCHK && (a >= 32'd2048);
    endfunction

    function automatic int idx(input logic [31:0] a);
        return int'(a[10:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; intr injects a write of 0x1 to 0x20 two cycles in, while busy.
    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input bit intr, input string tag);
        int lat;
        int nbusy;
        bit bad;
        bad = oob(a);
        @(negedge clk);
        req[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = wd;
        lat = 0; nbusy = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) req[d] = 1'b0;
            if (intr && i == 2) begin
                req[d] = 1'b1; wr[d] = 1'b1; addr[d] = 32'h20; wdata[d] = 32'h1;
            end
            if (intr && i == 3) req[d] = 1'b0;
            if (busy[d]) nbusy++;
            if (ack[d]) lat = i;
        end
        if (!bad) begin
            if (w) mmem[d][idx(a)] = wd;
            else   mrd[d] = mmem[d][idx(a)];
        end
        check($sformatf("%s latency", tag), 32'(lat), 32'(wc(d) + 2));
        check($sformatf("%s busy cycles", tag), 32'(nbusy), 32'(wc(d) + 2));
        check($sformatf("%s rdata", tag), rdata[d], mrd[d]);
`ifdef MEM_BOUNDS_CHECK_EN
        check($sformatf("%s err", tag), 32'(err[d]), 32'(bad));
`endif
        @(negedge clk);
        check($sformatf("%s ack pulse", tag), 32'(ack[d]), 32'd0);
        check($sformatf("%s idle", tag), 32'(busy[d]), 32'd0);
    endtask

    // Reads with iReq held high; acks must be WAIT_CYCLES+3 apart.
    task automatic b2b(input int d, input int n);
        int last;
        int k;
        last = 0; k = 0;
        @(negedge clk);
        req[d] = 1'b1; wr[d] = 1'b0; addr[d] = 32'($urandom_range(0, 15)) * 4;
        for (int cyc = 1; cyc <= 200 && k < n; cyc++) begin
            @(negedge clk);
            if (ack[d]) begin
                mrd[d] = mmem[d][idx(addr[d])];
                check($sformatf("b2b%0d gap %0d", d, k), 32'(cyc - last),
                      32'((k == 0) ? wc(d) + 2 : wc(d) + 3));
                check($sformatf("b2b%0d data %0d", d, k), rdata[d], mrd[d]);
                last = cyc;
                k++;
                if (k == n) req[d] = 1'b0;
                else        addr[d] = 32'($urandom_range(0, 15)) * 4;
            end
        end
        check($sformatf("b2b%0d count", d), 32'(k), 32'(n));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        bit          seen;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; mrd[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset ack%0d", d), 32'(ack[d]), 32'd0);
            check($sformatf("reset busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset rdata%0d", d), rdata[d], 32'd0);
`ifdef MEM_BOUNDS_CHECK_EN
            check($sformatf("reset err%0d", d), 32'(err[d]), 32'd0);
`endif
            rst_n[d] = 1'b1;
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++)
                txn(d, 1'b1, 32'(w * 4), $urandom, 1'b0, "init");

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "wr10");
        txn(0, 1'b0, 32'h10, 32'h0, 1'b0, "rd10");
        check("rd10 const", rdata[0], 32'hDEADBEEF);

        txn(1, 1'b1, 32'h0, 32'h12345678, 1'b0, "w0 wr0");
        txn(1, 1'b0, 32'h0, 32'h0, 1'b0, "w0 rd0");
        check("w0 rd0 const", rdata[1], 32'h12345678);

        txn(0, 1'b1, 32'h20, 32'hCAFE0020, 1'b0, "pre20");
        txn(0, 1'b0, 32'h40, 32'h0, 1'b1, "busy ignore");
        txn(0, 1'b0, 32'h20, 32'h0, 1'b0, "rd20");
        check("rd20 const", rdata[0], 32'hCAFE0020);

        txn(0, 1'b1, 32'h8, 32'h0BADF00D, 1'b0, "pre08");
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hAAAA5555;
        @(negedge clk);
        req[0] = 1'b0; rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1; mrd[0] = '0;
        check("rst busy", 32'(busy[0]), 32'd0);
        check("rst rdata", rdata[0], 32'd0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack[0]) seen = 1'b1;
        end
        check("rst no ack", 32'(seen), 32'd0);
        txn(0, 1'b0, 32'h8, 32'h0, 1'b0, "rd08");
        check("rd08 const", rdata[0], 32'h0BADF00D);

        txn(0, 1'b1, 32'h800, 32'h5A5A5A5A, 1'b0, "wr800");
        txn(0, 1'b0, 32'h0, 32'h0, 1'b0, "rd0 after 800");
`ifndef MEM_BOUNDS_CHECK_EN
        check("wrap word0 const", rdata[0], 32'h5A5A5A5A);
`endif

        b2b(0, 4);
        b2b(1, 4);

        repeat (30) begin
            int d;
            d = int'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a | (($urandom | 32'h800) & 32'hFFFF_F800);
            txn(d, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning the number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each access (0..15).
REQ-003 SHALL have port iClk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port nRst, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port iReq, input, 1, request strobe from the processor.
REQ-006 SHALL have port iWrite, input, 1, where 1 means write and 0 means read; sampled with iReq.
REQ-007 SHALL have port iAddr, input, 32, the byte address; word index is iAddr[log2(DEPTH)+1:2], and iAddr[1:0] is ignored.
REQ-008 SHALL have port iWData, input, 32, the write data (the processor's mem_data_out).
REQ-009 SHALL have port oRData, output, 32, the registered read data (the processor's mem_data_in).
REQ-010 SHALL have port oAck, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port oBusy, output, 1, high whenever the state is not IDLE.
REQ-012 SHALL have port oErr, output, 1, the out-of-range flag, valid with oAck (present only under REQ-026).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACCESS, DONE.
REQ-014 In IDLE with iReq=1, SHALL latch iAddr, iWData and iWrite, load the wait counter with WAIT_CYCLES, and go to WAIT, or directly to ACCESS if WAIT_CYCLES=0.
REQ-015 In WAIT, SHALL decrement the counter each cycle and go to ACCESS in the cycle after it reaches 1.
REQ-016 In ACCESS, SHALL issue exactly one array operation: a write of the latched data, or a synchronous read; it SHALL then go to DONE.
REQ-017 On entry to DONE, SHALL load oRData with the array output for reads; oRData SHALL be unchanged for writes.
REQ-018 In DONE, SHALL assert oAck=1 for exactly one cycle and then return to IDLE.
REQ-019 Latency: for a request sampled in cycle T, oAck SHALL be high in cycle T+WAIT_CYCLES+2.
REQ-020 SHALL ignore iReq in any state other than IDLE; no queueing and no error are produced.
REQ-021 iReq held high across DONE SHALL be accepted as a new request in the following IDLE cycle.
REQ-022 oRData SHALL hold its last read value until the next read completes.
REQ-023 A write followed by a read of the same address SHALL return the written data.

Reset
REQ-024 nRst=0 at a clock edge SHALL force IDLE, oAck=0, oBusy=0, oErr=0, oRData=0, and a wait counter of 0, from any state.
REQ-025 A reset asserted before ACCESS SHALL discard the pending write. Array contents are not reset.

Configuration
REQ-026 With MEM_BOUNDS_CHECK_EN defined, a latched address >= DEPTH*4 SHALL suppress the write and leave oRData unchanged. It SHALL also assert oErr=1 with oAck. oErr SHALL be 0 otherwise.
REQ-027 Without MEM_BOUNDS_CHECK_EN, the oErr port SHALL be absent. Addresses SHALL wrap modulo DEPTH words, with the upper bits ignored.

Structure
REQ-028 Shared package mem_pkg SHALL hold the state enum typedef, MEM_WORD_W=32, and the default DEPTH and WAIT_CYCLES constants.
REQ-029 The array SHALL be a sub-module mem_array: a single-port synchronous RAM with ports iClk, iWe, iAddr, iD, oQ, and a one-cycle read.

Verification
REQ-030 Write 0xDEADBEEF to address 0x10, then read 0x10: oRData=0xDEADBEEF and oAck in cycle T+4 for each request.
REQ-031 WAIT_CYCLES=0, read of address 0x0 preloaded with 0x12345678: oAck and oRData=0x12345678 in cycle T+2, and oBusy high for 2 cycles.
REQ-032 Pulse iReq at T, then pulse iReq (write 0x1 to address 0x20) at T+2 while busy: the second request is ignored, and the word at 0x20 is unchanged.
REQ-033 nRst=0 during WAIT of a write of 0xAAAA5555 to address 0x8: oAck never asserts, and a subsequent read of 0x8 returns the prior contents.
REQ-034 MEM_BOUNDS_CHECK_EN with DEPTH=512, write to address 0x800: oErr=1 with oAck, and address 0x0 is unchanged. Without the macro, the same write lands at word 0.
REQ-035 Back-to-back reads with iReq held high: an oAck pulse every WAIT_CYCLES+3 cycles, with correct data each time.
